// File: rtl/mem_arbiter_n_if.sv
// Request/grant bundle between the memory masters and mem_arbiter_n.
// nb_timeouts is present only when MEM_ARB_URGENT_TIMEOUT_EN is defined.
interface mem_arbiter_n_if #(
    parameter int N_MASTERS = 3,
    parameter int HOLD_MAX  = 2,
    parameter int CNT_W     = 32
);
    logic [N_MASTERS-1:0]           req;
    logic [N_MASTERS-1:0]           done;
    logic [N_MASTERS-1:0]           grant;
    logic [$clog2(N_MASTERS+1)-1:0] grant_id;
    logic [$clog2(HOLD_MAX+1)-1:0]  grant_cnt;
    logic                           preempt_grant;
    logic [CNT_W-1:0]               nb_interrupts;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
    logic [CNT_W-1:0]               nb_timeouts;

    modport master (
        output req, done,
        input  grant, grant_id, grant_cnt, preempt_grant, nb_interrupts, nb_timeouts
    );
    modport slave (
        input  req, done,
        output grant, grant_id, grant_cnt, preempt_grant, nb_interrupts, nb_timeouts
    );
`else
    modport master (
        output req, done,
        input  grant, grant_id, grant_cnt, preempt_grant, nb_interrupts
    );
    modport slave (
        input  req, done,
        output grant, grant_id, grant_cnt, preempt_grant, nb_interrupts
    );
`endif
endinterface

// File: rtl/mem_arbiter_n.sv
// Shared memory port arbiter: urgent master 0 with preemption, round-robin among 1..N-1.
// Optional macro MEM_ARB_URGENT_TIMEOUT_EN bounds idle-won urgent grants to URGENT_TMO cycles.
module mem_arbiter_n #(
    parameter int N_MASTERS  = 3,
    parameter int HOLD_MAX   = 2,
    parameter int CNT_W      = 32,
    parameter int URGENT_TMO = 64
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_n_if.slave bus
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int GID_W = $clog2(N_MASTERS + 1);
    localparam int CW    = $clog2(HOLD_MAX + 1);

    if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n
        $error("mem_arbiter_n: N_MASTERS must be in 2..16");
    end
    if (HOLD_MAX < 2) begin : g_bad_hold
        $error("mem_arbiter_n: HOLD_MAX must be >= 2");
    end
    if (URGENT_TMO < 1) begin : g_bad_tmo
        $error("mem_arbiter_n: URGENT_TMO must be >= 1");
    end

    // One-hot so that any corrupted encoding falls into the default recovery arm
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        URG_LONG = 4'b0010,
        URG_PRE  = 4'b0100,
        NRM      = 4'b1000
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [IDX_W-1:0] holder_q, holder_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] nb_int_q, nb_int_d;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
    localparam int TW = $clog2(URGENT_TMO + 1);
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] nb_tmo_q, nb_tmo_d;
`endif

    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    int               rr_best;
    int               rr_dist;
    logic             do_arb;
    logic             excl_urgent;
    logic [N_MASTERS-1:0] grant_o;
    logic [GID_W-1:0]     grant_id_o;

    // Round-robin candidate: requester with the smallest wrapped distance from rr_ptr
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_best  = N_MASTERS;
        rr_dist  = 0;
        for (int i = 1; i < N_MASTERS; i++) begin
            rr_dist = (i - int'(rr_ptr_q) + N_MASTERS - 1) % (N_MASTERS - 1);
            if (bus.req[i] && rr_dist < rr_best) begin
                rr_best  = rr_dist;
                rr_idx   = IDX_W'(i);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        mode_d      = mode_q;
        holder_d    = holder_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        nb_int_d    = nb_int_q;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
        tmo_d       = tmo_q;
        nb_tmo_d    = nb_tmo_q;
`endif
        do_arb      = 1'b0;
        excl_urgent = 1'b0;

        case (mode_q)
            IDLE: do_arb = 1'b1;
            URG_LONG: begin
                if (bus.done[0]) begin
                    do_arb      = 1'b1;
                    excl_urgent = 1'b1;
                end
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
                else if (tmo_q >= TW'(URGENT_TMO)) begin
                    do_arb      = 1'b1;
                    excl_urgent = 1'b1;
                    if (nb_tmo_q != '1) nb_tmo_d = nb_tmo_q + CNT_W'(1);
                end
`endif
                else begin
                    if (cnt_q < CW'(HOLD_MAX)) cnt_d = cnt_q + CW'(1);
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            URG_PRE: begin
                if (bus.done[0] || cnt_q >= CW'(HOLD_MAX)) begin
                    do_arb      = 1'b1;
                    excl_urgent = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NRM: begin
                // A holder's done wins over a simultaneous urgent request: release, not preemption
                if (bus.done[holder_q]) begin
                    do_arb = 1'b1;
                end else if (bus.req[0] && cnt_q < CW'(HOLD_MAX)) begin
                    mode_d   = URG_PRE;
                    holder_d = '0;
                    cnt_d    = CW'(1);
                    if (nb_int_q != '1) nb_int_d = nb_int_q + CNT_W'(1);
                end else if (cnt_q >= CW'(HOLD_MAX)) begin
                    do_arb = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                mode_d   = IDLE;
                holder_d = '0;
                cnt_d    = '0;
            end
        endcase

        if (do_arb) begin
            if (bus.req[0] && !excl_urgent) begin
                mode_d   = URG_LONG;
                holder_d = '0;
                cnt_d    = CW'(1);
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
                tmo_d    = TW'(1);
`endif
            end else if (rr_found) begin
                mode_d   = NRM;
                holder_d = rr_idx;
                cnt_d    = CW'(1);
                rr_ptr_d = (rr_idx == IDX_W'(N_MASTERS - 1)) ? IDX_W'(1) : rr_idx + IDX_W'(1);
            end else begin
                mode_d   = IDLE;
                holder_d = '0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= IDLE;
            holder_q <= '0;
            rr_ptr_q <= IDX_W'(1);
            cnt_q    <= '0;
            nb_int_q <= '0;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
            tmo_q    <= '0;
            nb_tmo_q <= '0;
`endif
        end else begin
            mode_q   <= mode_d;
            holder_q <= holder_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            nb_int_q <= nb_int_d;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
            tmo_q    <= tmo_d;
            nb_tmo_q <= nb_tmo_d;
`endif
        end
    end

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        case (mode_q)
            URG_LONG, URG_PRE: begin
                grant_o[0] = 1'b1;
                grant_id_o = GID_W'(1);
            end
            NRM: begin
                grant_o[holder_q] = 1'b1;
                grant_id_o        = GID_W'(holder_q) + GID_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.grant         = grant_o;
    assign bus.grant_id      = grant_id_o;
    assign bus.grant_cnt     = (mode_q == URG_LONG || mode_q == URG_PRE || mode_q == NRM) ? cnt_q : '0;
    assign bus.preempt_grant = (mode_q == URG_PRE);
    assign bus.nb_interrupts = nb_int_q;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
    assign bus.nb_timeouts   = nb_tmo_q;
`endif
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n (N=3, HOLD_MAX=2, CNT_W=4): directed scenarios plus random traffic,
// all checked every cycle against an owner/age model; honours MEM_ARB_URGENT_TIMEOUT_EN.
module tb_mem_arbiter_n;
    localparam int N       = 3;
    localparam int HM      = 2;
    localparam int CW      = 4;
    localparam int TMO     = 64;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic check_en;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter_n_if #(.N_MASTERS(N), .HOLD_MAX(HM), .CNT_W(CW)) bus ();

    mem_arbiter_n #(
        .N_MASTERS(N), .HOLD_MAX(HM), .CNT_W(CW), .URGENT_TMO(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Model: who owns the port, whether it was taken by preemption, and how long it has been held
    int m_owner;
    bit m_pre;
    int m_age;
    int m_ptr;
    int m_nint;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
    int m_ntmo;
`endif

    task automatic model_reset();
        m_owner = -1;
        m_pre   = 1'b0;
        m_age   = 0;
        m_ptr   = 1;
        m_nint  = 0;
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
        m_ntmo  = 0;
`endif
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit free_now;
        bit excl0;
        int order[$];
        free_now = 1'b0;
        excl0    = 1'b0;
        if (m_owner < 0) begin
            free_now = 1'b1;
        end else if (m_owner == 0 && !m_pre) begin
            if (d[0]) begin
                free_now = 1'b1;
                excl0    = 1'b1;
            end
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
            else if (m_age == TMO) begin
                free_now = 1'b1;
                excl0    = 1'b1;
                m_ntmo   = (m_ntmo < CNT_MAX) ? m_ntmo + 1 : CNT_MAX;
            end
`endif
            else m_age++;
        end else if (m_owner == 0) begin
            if (d[0] || m_age == HM) begin
                free_now = 1'b1;
                excl0    = 1'b1;
            end else m_age++;
        end else begin
            if (d[m_owner]) free_now = 1'b1;
            else if (r[0] && m_age < HM) begin
                m_owner = 0;
                m_pre   = 1'b1;
                m_age   = 1;
                m_nint  = (m_nint < CNT_MAX) ? m_nint + 1 : CNT_MAX;
            end else if (m_age == HM) free_now = 1'b1;
            else m_age++;
        end

        if (free_now) begin
            m_owner = -1;
            m_pre   = 1'b0;
            m_age   = 0;
            if (r[0] && !excl0) begin
                m_owner = 0;
                m_age   = 1;
            end else begin
                for (int k = 0; k < N - 1; k++) order.push_back(((m_ptr - 1 + k) % (N - 1)) + 1);
                foreach (order[j]) if (m_owner < 0 && r[order[j]]) m_owner = order[j];
                if (m_owner > 0) begin
                    m_age = 1;
                    m_ptr = (m_owner % (N - 1)) + 1;
                end
            end
        end
    endtask

    function automatic int exp_grant();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction

    function automatic int exp_gid();
        return m_owner + 1;
    endfunction

    function automatic int exp_cnt();
        if (m_owner < 0) return 0;
        if (m_owner == 0 && !m_pre) return (m_age < HM) ? m_age : HM;
        return m_age;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Compare process: every cycle, mid-low phase, DUT against the model
    always @(negedge clk) begin
        if (check_en) begin
            check_output("grant",         int'(bus.grant),         exp_grant());
            check_output("grant_id",      int'(bus.grant_id),      exp_gid());
            check_output("grant_cnt",     int'(bus.grant_cnt),     exp_cnt());
            check_output("preempt_grant", int'(bus.preempt_grant), int'(m_pre));
            check_output("nb_interrupts", int'(bus.nb_interrupts), m_nint);
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
            check_output("nb_timeouts",   int'(bus.nb_timeouts),   m_ntmo);
`endif
        end
    end

    task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_grant"},    int'(bus.grant),         0);
        check_output({tag, "_grant_id"}, int'(bus.grant_id),      0);
        check_output({tag, "_cnt"},      int'(bus.grant_cnt),     0);
        check_output({tag, "_preempt"},  int'(bus.preempt_grant), 0);
        check_output({tag, "_nb_int"},   int'(bus.nb_interrupts), 0);
    endtask

    int exp_rr_gid[5] = '{2, 2, 3, 3, 2};
    int exp_rr_cnt[5] = '{1, 2, 1, 2, 1};

    initial begin
        reset    = 1'b1;
        check_en = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        check_en = 1'b1;
        check_idle_outputs("reset");

        // Round-robin between masters 1 and 2, each capped at HOLD_MAX cycles
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(3'b110, 3'b000);
            check_output("rr_gid", int'(bus.grant_id), exp_rr_gid[i]);
            check_output("rr_cnt", int'(bus.grant_cnt), exp_rr_cnt[i]);
        end
        check_output("rr_nb_int", int'(bus.nb_interrupts), 0);

        // Preemption of master 1, then master 1 regranted after the capped urgent grant
        do_reset();
        apply_stimulus(3'b010, 3'b000);
        check_output("pre_setup_gid", int'(bus.grant_id), 2);
        apply_stimulus(3'b011, 3'b000);
        check_output("pre_grant",   int'(bus.grant), 1);
        check_output("pre_flag",    int'(bus.preempt_grant), 1);
        check_output("pre_nb_int",  int'(bus.nb_interrupts), 1);
        apply_stimulus(3'b011, 3'b000);
        check_output("pre_cnt2",    int'(bus.grant_cnt), 2);
        apply_stimulus(3'b011, 3'b000);
        check_output("pre_back_gid", int'(bus.grant_id), 2);
        check_output("pre_back_flag", int'(bus.preempt_grant), 0);

        // Holder done together with urgent request: release, not a preemption
        do_reset();
        apply_stimulus(3'b100, 3'b000);
        check_output("rel_setup_gid", int'(bus.grant_id), 3);
        apply_stimulus(3'b101, 3'b100);
        check_output("rel_gid",    int'(bus.grant_id), 1);
        check_output("rel_flag",   int'(bus.preempt_grant), 0);
        check_output("rel_nb_int", int'(bus.nb_interrupts), 0);

        // Long urgent hold from idle
        do_reset();
        repeat (100) apply_stimulus(3'b001, 3'b000);
        check_output("long_grant", int'(bus.grant), 1);
        check_output("long_cnt",   int'(bus.grant_cnt), 2);
`ifdef MEM_ARB_URGENT_TIMEOUT_EN
        check_output("long_nb_tmo", int'(bus.nb_timeouts), 1);
`endif

        // Saturation of the preemption counter, then asynchronous reset mid-grant
        do_reset();
        apply_stimulus(3'b010, 3'b000);
        repeat (17) begin
            apply_stimulus(3'b011, 3'b000);
            apply_stimulus(3'b010, 3'b001);
        end
        check_output("sat_nb_int", int'(bus.nb_interrupts), CNT_MAX);
        check_output("sat_gid",    int'(bus.grant_id), 2);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(3'b110, 3'b000);
        check_output("post_rst_gid", int'(bus.grant_id), 2);

        // Random traffic; urgent requests kept sparse so round-robin gets exercised
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] d;
            r    = N'($urandom);
            r[0] = ($urandom_range(0, 3) == 0);
            d    = N'($urandom) & N'($urandom);
            apply_stimulus(r, d);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
